// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream zero-checker.
// Holds the per-channel checker FSM state encoding.
package hwpe_stream_package;

  typedef enum logic [1:0] {
    ZC_OK      = 2'd0,
    ZC_SUSPECT = 2'd1,
    ZC_FAULT   = 2'd2
  } zc_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE stream interface: valid/ready handshake with data and byte strobe.
// Handshake: a beat transfers on a rising edge where valid and ready are both 1;
// the source holds valid/data/strb stable until that beat, ready may change freely.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source  (output valid, data, strb, input  ready);
  modport sink    (input  valid, data, strb, output ready);
  modport monitor (input  valid, ready, data, strb);
endinterface

// File: rtl/hwpe_stream_zero_checker_chan.sv
// One channel of the zero checker: OK / SUSPECT / FAULT state machine with a
// run counter of consecutive mismatch cycles. fault_event pulses in the cycle
// the channel is about to enter FAULT (combinational on current state and m).
module hwpe_stream_zero_checker_chan
  import hwpe_stream_package::*;
#(
  parameter int unsigned FAULT_THRESHOLD = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      m,
  input  logic      clear,
  output zc_state_e state,
  output logic      fault_event
);

  localparam int unsigned RW = $clog2(FAULT_THRESHOLD + 1);
  localparam logic [RW:0] THR = (RW+1)'(FAULT_THRESHOLD);

  logic [RW-1:0] run_q;
  logic [RW:0]   run_inc;

  assign run_inc = {1'b0, run_q} + 1'b1;

  // Detect the mismatch that completes the threshold run.
  always_comb begin
    fault_event = 1'b0;
    if (m) begin
      if (state == ZC_OK && FAULT_THRESHOLD == 1) fault_event = 1'b1;
      if (state == ZC_SUSPECT && run_inc == THR)  fault_event = 1'b1;
    end
  end

  // State and run counter; entering FAULT wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ZC_OK;
      run_q <= '0;
    end else if (fault_event) begin
      state <= ZC_FAULT;
      run_q <= run_inc[RW-1:0];
    end else if (clear) begin
      state <= ZC_OK;
      run_q <= '0;
    end else begin
      case (state)
        ZC_OK: begin
          if (m) begin
            state <= ZC_SUSPECT;
            run_q <= RW'(1);
          end
        end
        ZC_SUSPECT: begin
          if (m) begin
            run_q <= run_inc[RW-1:0];
          end else begin
            state <= ZC_OK;
            run_q <= '0;
          end
        end
        ZC_FAULT: ;
        default: begin
          state <= ZC_OK;
          run_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hwpe_stream_zero_checker.sv
// Zero-network checker: compares the handshake of each zero stream against its
// normal stream, flags mismatches, confirms persistent faults per channel,
// captures the first faulty channel and counts fault events.
// Optional macro HWPE_STREAM_ZERO_CHECKER_CNT_EN builds the saturating fault
// event counter; without it fault_count_o is tied to zero.
// Per-channel state is exposed through fault_sticky_o (1 while in FAULT).
module hwpe_stream_zero_checker
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_CHANNELS     = 4,
  parameter int unsigned FAULT_THRESHOLD = 2,
  parameter int unsigned STRB_ALWAYS     = 1,
  parameter int unsigned CNT_WIDTH       = 8,
  localparam int unsigned IW = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  hwpe_stream_intf_stream.monitor normal_i [NB_CHANNELS-1:0],
  hwpe_stream_intf_stream.sink    zero_i   [NB_CHANNELS-1:0],
  input  logic                   clear_i,
  output logic                   fault_detected_o,
  output logic [NB_CHANNELS-1:0] fault_sticky_o,
  output logic                   first_fault_valid_o,
  output logic [IW-1:0]          first_fault_idx_o,
  output logic [CNT_WIDTH-1:0]   fault_count_o
);

  logic [NB_CHANNELS-1:0] m;
  logic [NB_CHANNELS-1:0] evt;
  logic                   evt_any;
  logic [IW-1:0]          evt_idx;

  for (genvar c = 0; c < NB_CHANNELS; c++) begin : g_chan
    logic      strb_diff;
    zc_state_e chan_state;

    // The zero stream is consumed in lockstep with the normal stream.
    assign zero_i[c].ready = normal_i[c].ready;
    assign strb_diff       = (normal_i[c].strb != zero_i[c].strb);
    assign m[c] = (zero_i[c].valid != normal_i[c].valid) |
                  ((STRB_ALWAYS != 0) ? strb_diff : (strb_diff & normal_i[c].valid));

    hwpe_stream_zero_checker_chan #(
      .FAULT_THRESHOLD(FAULT_THRESHOLD)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .m          (m[c]),
      .clear      (clear_i),
      .state      (chan_state),
      .fault_event(evt[c])
    );

    assign fault_sticky_o[c] = (chan_state == ZC_FAULT);
  end

  // Lowest-index channel with a fault event this cycle.
  always_comb begin
    evt_any = |evt;
    evt_idx = '0;
    for (int i = NB_CHANNELS - 1; i >= 0; i--) begin
      if (evt[i]) evt_idx = IW'(i);
    end
  end

  // Registered OR of raw mismatches; not affected by clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fault_detected_o <= 1'b0;
    else         fault_detected_o <= |m;
  end

  // First-fault capture; clear empties it, same-cycle events then re-arm it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_fault_valid_o <= 1'b0;
      first_fault_idx_o   <= '0;
    end else begin
      if (clear_i) begin
        first_fault_valid_o <= 1'b0;
        first_fault_idx_o   <= '0;
      end
      if ((!first_fault_valid_o || clear_i) && evt_any) begin
        first_fault_valid_o <= 1'b1;
        first_fault_idx_o   <= evt_idx;
      end
    end
  end

`ifdef HWPE_STREAM_ZERO_CHECKER_CNT_EN
  localparam int unsigned PW = $clog2(NB_CHANNELS + 1);
  localparam int unsigned SW = CNT_WIDTH + PW;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_WIDTH{1'b1}});

  logic [PW-1:0]        evt_cnt;
  logic [SW-1:0]        cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Popcount of events added on top of the (possibly cleared) count.
  always_comb begin
    evt_cnt = '0;
    for (int i = 0; i < NB_CHANNELS; i++) begin
      evt_cnt = evt_cnt + PW'(evt[i]);
    end
    cnt_sum = (clear_i ? '0 : SW'(cnt_q)) + SW'(evt_cnt);
  end

  // Saturating event counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               cnt_q <= '0;
    else if (cnt_sum > CNT_MAX) cnt_q <= {CNT_WIDTH{1'b1}};
    else                       cnt_q <= cnt_sum[CNT_WIDTH-1:0];
  end

  assign fault_count_o = cnt_q;
`else
  assign fault_count_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_zero_checker.sv
// Directed bench for hwpe_stream_zero_checker: three instances share the same
// stimulus (default config, STRB_ALWAYS=0, CNT_WIDTH=2).
module tb_hwpe_stream_zero_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clear;
  logic [3:0] n_valid, z_valid, n_ready;
  logic [3:0] n_strb [4];
  logic [3:0] z_strb [4];

  int tests = 0;
  int fails = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) norm [3:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) za   [3:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) zb   [3:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) zc   [3:0] ();

  logic [3:0] zr_a, zr_b, zr_c;

  for (genvar c = 0; c < 4; c++) begin : g_if
    assign norm[c].valid = n_valid[c];
    assign norm[c].ready = n_ready[c];
    assign norm[c].strb  = n_strb[c];
    assign norm[c].data  = '0;
    assign za[c].valid = z_valid[c];
    assign za[c].strb  = z_strb[c];
    assign za[c].data  = '0;
    assign zb[c].valid = z_valid[c];
    assign zb[c].strb  = z_strb[c];
    assign zb[c].data  = '0;
    assign zc[c].valid = z_valid[c];
    assign zc[c].strb  = z_strb[c];
    assign zc[c].data  = '0;
    assign zr_a[c] = za[c].ready;
    assign zr_b[c] = zb[c].ready;
    assign zr_c[c] = zc[c].ready;
  end

  logic       det_a, det_b, det_c;
  logic [3:0] st_a, st_b, st_c;
  logic       fv_a, fv_b, fv_c;
  logic [1:0] ix_a, ix_b, ix_c;
  logic [7:0] cn_a, cn_b;
  logic [1:0] cn_c;

  hwpe_stream_zero_checker u_dut (
    .clk_i(clk), .rst_ni(rst_n), .normal_i(norm), .zero_i(za), .clear_i(clear),
    .fault_detected_o(det_a), .fault_sticky_o(st_a), .first_fault_valid_o(fv_a),
    .first_fault_idx_o(ix_a), .fault_count_o(cn_a)
  );

  hwpe_stream_zero_checker #(.STRB_ALWAYS(0)) u_dut_s0 (
    .clk_i(clk), .rst_ni(rst_n), .normal_i(norm), .zero_i(zb), .clear_i(clear),
    .fault_detected_o(det_b), .fault_sticky_o(st_b), .first_fault_valid_o(fv_b),
    .first_fault_idx_o(ix_b), .fault_count_o(cn_b)
  );

  hwpe_stream_zero_checker #(.CNT_WIDTH(2)) u_dut_c2 (
    .clk_i(clk), .rst_ni(rst_n), .normal_i(norm), .zero_i(zc), .clear_i(clear),
    .fault_detected_o(det_c), .fault_sticky_o(st_c), .first_fault_valid_o(fv_c),
    .first_fault_idx_o(ix_c), .fault_count_o(cn_c)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear   = 1'b0;
    n_valid = 4'b0000;
    z_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n_strb[i] = 4'h0;
      z_strb[i] = 4'h0;
    end
  endtask

  // Expected counter value for the build: counter absent means constant zero.
  function automatic logic [31:0] ec(input int n);
`ifdef HWPE_STREAM_ZERO_CHECKER_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic d, input logic [3:0] s,
                       input logic v, input logic [1:0] ix, input logic [31:0] cn);
    chk({tag, ".det"},    32'(det_a), 32'(d));
    chk({tag, ".sticky"}, 32'(st_a),  32'(s));
    chk({tag, ".ffv"},    32'(fv_a),  32'(v));
    chk({tag, ".idx"},    32'(ix_a),  32'(ix));
    chk({tag, ".cnt"},    32'(cn_a),  cn);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    n_ready = 4'hF;
    idle();
    tick();
    tick();
    chk_a("reset", 1'b0, 4'h0, 1'b0, 2'd0, ec(0));
    chk("reset.s0.sticky", 32'(st_b), 32'h0);
    chk("reset.c2.cnt",    32'(cn_c), 32'h0);

    // ready passthrough from normal to zero stream
    n_ready = 4'b0101;
    #1;
    chk("ready.a", 32'(zr_a), 32'h5);
    chk("ready.b", 32'(zr_b), 32'h5);
    chk("ready.c", 32'(zr_c), 32'h5);
    n_ready = 4'hF;
    #1;
    chk("ready.a.all", 32'(zr_a), 32'hF);

    rst_n = 1'b1;
    tick();

    // single-cycle valid mismatch on ch2: detected next cycle, no sticky
    z_valid = 4'b0100;
    tick();
    idle();
    chk("one.det",    32'(det_a), 32'h1);
    chk("one.sticky", 32'(st_a),  32'h0);
    tick();
    chk_a("one.after", 1'b0, 4'h0, 1'b0, 2'd0, ec(0));

    // ch1 two consecutive mismatches -> FAULT
    n_valid = 4'b0010;
    tick();
    chk("b.det",     32'(det_a), 32'h1);
    chk("b.sticky0", 32'(st_a),  32'h0);
    tick();
    idle();
    chk_a("b.fault", 1'b1, 4'b0010, 1'b1, 2'd1, ec(1));
    chk("b.s0.sticky", 32'(st_b), 32'h2);
    chk("b.c2.cnt",    32'(cn_c), ec(1));

    // clear with nothing pending
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_a("clr", 1'b0, 4'h0, 1'b0, 2'd0, ec(0));

    // ch3 and ch0 reach threshold together
    z_valid = 4'b1001;
    tick();
    tick();
    idle();
    chk_a("c.pair", 1'b1, 4'b1001, 1'b1, 2'd0, ec(2));
    chk("c.c2.cnt", 32'(cn_c), ec(2));

    // ch1 joins; capture keeps idx 0
    n_valid = 4'b0010;
    tick();
    tick();
    idle();
    chk_a("d.ch1", 1'b1, 4'b1011, 1'b1, 2'd0, ec(3));

    // ch2 enters FAULT in the clear cycle: set wins, others clear
    z_valid = 4'b0100;
    tick();
    clear = 1'b1;
    tick();
    idle();
    chk_a("d.setwins", 1'b1, 4'b0100, 1'b1, 2'd2, ec(1));
    chk("d.s0.sticky", 32'(st_b), 32'h4);
    chk("d.c2.cnt",    32'(cn_c), ec(1));

    // three more events: 1+3 = 4, 2-bit counter saturates at 3
    z_valid = 4'b1011;
    tick();
    tick();
    idle();
    chk_a("e.sat", 1'b1, 4'b1111, 1'b1, 2'd2, ec(4));
    chk("e.c2.sat", 32'(cn_c), ec(3));

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("f.clr.sticky", 32'(st_a), 32'h0);

    // strb differs while normal valid=0
    n_strb[1] = 4'hF;
    z_strb[1] = 4'h0;
    tick();
    idle();
    chk("f.strb.always", 32'(det_a), 32'h1);
    chk("f.strb.gated",  32'(det_b), 32'h0);
    tick();
    // strb differs with both valid
    n_valid   = 4'b0010;
    z_valid   = 4'b0010;
    n_strb[1] = 4'hF;
    z_strb[1] = 4'h0;
    tick();
    idle();
    chk("f.strb.valid.s0", 32'(det_b), 32'h1);
    tick();
    chk("f.quiet.s0",     32'(det_b), 32'h0);
    chk("f.quiet.sticky", 32'(st_a),  32'h0);

    // async reset mid-SUSPECT, mismatch held through release
    z_valid = 4'b0001;
    tick();
    chk("g.pre.det", 32'(det_a), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_a("g.async", 1'b0, 4'h0, 1'b0, 2'd0, ec(0));
    chk("g.async.c2.det", 32'(det_c), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    idle();
    chk("g.fresh.det",    32'(det_a), 32'h1);
    chk("g.fresh.sticky", 32'(st_a),  32'h0);
    tick();
    chk("g.end.sticky", 32'(st_a), 32'h0);
    chk("g.end.det",    32'(det_a), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
